// File: rtl/psum_accumulator.sv
// Accumulates a window of signed tile partial sums into a saturating accumulator
// and holds the result until the consumer takes it.
module psum_accumulator #(
    parameter int PSUM_W = 22,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psum_valid,
    input  logic [PSUM_W-1:0] psum,
    input  logic [CNT_W-1:0]  num_tiles,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_sat,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                   state, state_nxt;
    logic signed [ACC_W-1:0]  acc, acc_nxt;
    logic        [CNT_W-1:0]  cnt, cnt_nxt;
    logic        [CNT_W-1:0]  tgt, tgt_nxt;
    logic                     sat_nxt;
    logic                     ovr_nxt;
    logic                     start;
    logic        [CNT_W-1:0]  tgt_start;
    logic signed [ACC_W-1:0]  psum_ext;
    logic signed [ACC_W:0]    sum;

    // Clip a one-bit-wide sum back into the accumulator range.
    function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W:0] s);
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    function automatic logic clipped(input logic signed [ACC_W:0] s);
        return s[ACC_W] != s[ACC_W-1];
    endfunction

    assign psum_ext  = {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};
    assign sum       = {acc[ACC_W-1], acc} + {psum_ext[ACC_W-1], psum_ext};
    assign tgt_start = (num_tiles == '0) ? CNT_W'(1) : num_tiles;

    // A new window opens from IDLE, or from HOLD in the same cycle as the handoff.
    assign start = psum_valid && ((state == IDLE) || (state == HOLD && acc_ready));

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        tgt_nxt   = tgt;
        sat_nxt   = acc_sat;
        ovr_nxt   = overrun;
        unique case (state)
            IDLE: ;
            ACCUM: begin
                if (psum_valid) begin
                    acc_nxt = saturate(sum);
                    sat_nxt = acc_sat | clipped(sum);
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt + CNT_W'(1) == tgt)
                        state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (acc_ready) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                end else if (psum_valid) begin
                    ovr_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (start) begin
            acc_nxt   = psum_ext;
            cnt_nxt   = CNT_W'(1);
            tgt_nxt   = tgt_start;
            sat_nxt   = 1'b0;
            state_nxt = (tgt_start == CNT_W'(1)) ? HOLD : ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            tgt     <= '0;
            acc_sat <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            tgt     <= tgt_nxt;
            acc_sat <= sat_nxt;
            overrun <= ovr_nxt;
        end
    end

    assign acc_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign acc_out   = acc;

endmodule
